inst_fetch_queue: RTL

- Instruction fetch stage directly upstream of CORE decode.
- Drives program-memory addresses, captures returned instruction words into a small prefetch FIFO, and presents them to the core with a valid/ready handshake.
- Redirect input (branch/jump) flushes queued and in-flight fetches and restarts fetching at a new address.

---
 rtl/inst_fetch_queue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues program-memory reads and buffers the returned words for decode.
// Defining FETCH_STATS_EN adds the stat_fetched / stat_flushed counters.
module inst_fetch_queue #(
  parameter int INST_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] progmem_addr,
  input  logic [INST_W-1:0] progmem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc_r;
  logic              inflight_r;
  logic              inflight_epoch_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic              epoch_r;

  logic [INST_W-1:0] fifo_data_r [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_r   [DEPTH];
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;

  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              inflight_live_s;
  logic [CW-1:0]     occ_s;

  assign progmem_addr = fetch_pc_r;
  assign inst_valid   = (count_r != CW'(0));
  assign inst_data    = fifo_data_r[rd_ptr_r];
  assign inst_pc      = fifo_pc_r[rd_ptr_r];

  // Handshake, capture and issue decisions for the current cycle
  always_comb begin
    pop_s           = inst_valid && inst_ready;
    inflight_live_s = inflight_r && (inflight_epoch_r == epoch_r);
    occ_s           = count_r + CW'(inflight_r) - CW'(pop_s);
    push_s          = 1'b0;
    issue_s         = 1'b0;
    if (inflight_live_s && !redirect_valid) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    // Reserving a slot for the in-flight word guarantees the FIFO never overflows
    if (en && !redirect_valid && (occ_s < CW'(DEPTH))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch PC, in-flight tracking and redirect epoch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r       <= ADDR_W'(RESET_PC);
      inflight_r       <= 1'b0;
      inflight_epoch_r <= 1'b0;
      inflight_pc_r    <= '0;
      epoch_r          <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_addr;
      epoch_r    <= ~epoch_r;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r    <= fetch_pc_r;
        inflight_epoch_r <= epoch_r;
        fetch_pc_r       <= fetch_pc_r + ADDR_W'(1);
      end
    end
  end

  // Prefetch FIFO storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_r[i] <= '0;
        fifo_pc_r[i]   <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= progmem_data;
        fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
        wr_ptr_r              <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] drop_cnt_s;

  // Words lost to a redirect: queued entries not handed over this cycle plus a live response
  always_comb begin
    drop_cnt_s = 32'(count_r) - 32'(pop_s) + 32'(inflight_live_s);
  end

  // Statistics counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= 32'd0;
      stat_flushed <= 32'd0;
    end else begin
      stat_fetched <= stat_fetched + 32'(push_s);
      if (redirect_valid) begin
        stat_flushed <= stat_flushed + drop_cnt_s;
      end
    end
  end
`endif

endmodule
